mem_alloc_client: RTL

- Counterpart of the memory allocation unit; sits between the allocator and the Rx writer / Tx reader of the queueing system.
- Alloc side: takes addresses from the allocator's valid/ack handshake and prefetches them into a small FIFO for the Rx packet writer.
- Free side: queues buffer addresses released by the Tx reader and replays them to the allocator's free/ack handshake.
- Tracks outstanding allocated blocks and flags protocol errors.

---
 rtl/mem_alloc_client.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_alloc_client.sv
// mem_alloc_client: client side of the memory allocation unit.
// Prefetches allocated buffer addresses for the Rx writer and returns
// released addresses from the Tx reader to the allocator.
// Optional feature: define MEM_ALLOC_CLIENT_ADDR_CHECK_EN to drop and flag
// addresses whose in-block offset bits are not zero.
module mem_alloc_client #(
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int PACKET_ADDRESS_BITS = 11,
    parameter int PACKET_SIZE_WIDTH   = 11,
    parameter int PREFETCH_DEPTH      = 4,
    parameter int FREE_DEPTH          = 8,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [AXI_ADDR_WIDTH-1:0]    alloc_addr_i,
    input  logic                         alloc_valid_i,
    output logic                         alloc_ack_o,
    output logic [PACKET_SIZE_WIDTH-1:0] alloc_len_o,
    output logic [AXI_ADDR_WIDTH-1:0]    buf_addr_o,
    output logic                         buf_addr_valid_o,
    input  logic                         buf_addr_ready_i,
    input  logic [AXI_ADDR_WIDTH-1:0]    rel_addr_i,
    input  logic                         rel_valid_i,
    output logic                         rel_ready_o,
    output logic [AXI_ADDR_WIDTH-1:0]    free_mem_addr_o,
    output logic                         free_mem_o,
    input  logic                         free_mem_ack_i,
    output logic [CNT_WIDTH-1:0]         outstanding_o,
    output logic                         err_o
);

    localparam int PF_AW = $clog2(PREFETCH_DEPTH);
    localparam int FR_AW = $clog2(FREE_DEPTH);

    localparam logic [PF_AW:0]     PF_FULL  = (PF_AW+1)'(PREFETCH_DEPTH);
    localparam logic [PF_AW:0]     PF_ONE   = (PF_AW+1)'(1);
    localparam logic [PF_AW-1:0]   PF_INC   = PF_AW'(1);
    localparam logic [FR_AW:0]     FR_FULL  = (FR_AW+1)'(FREE_DEPTH);
    localparam logic [FR_AW:0]     FR_ONE   = (FR_AW+1)'(1);
    localparam logic [FR_AW-1:0]   FR_INC   = FR_AW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Reject parameter sets the pointer arithmetic cannot support.
    if (PREFETCH_DEPTH < 2 || (PREFETCH_DEPTH & (PREFETCH_DEPTH - 1)) != 0) begin : g_bad_prefetch_depth
        $error("PREFETCH_DEPTH must be a power of two and at least 2");
    end
    if (FREE_DEPTH < 2 || (FREE_DEPTH & (FREE_DEPTH - 1)) != 0) begin : g_bad_free_depth
        $error("FREE_DEPTH must be a power of two and at least 2");
    end
    if (PACKET_ADDRESS_BITS < 1 || PACKET_ADDRESS_BITS >= AXI_ADDR_WIDTH) begin : g_bad_block_bits
        $error("PACKET_ADDRESS_BITS must lie inside the address width");
    end

    typedef enum logic {
        FREE_IDLE = 1'b0,
        FREE_REQ  = 1'b1
    } free_state_e;

    logic [AXI_ADDR_WIDTH-1:0] pf_mem_q [PREFETCH_DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] pf_mem_d [PREFETCH_DEPTH];
    logic [PF_AW-1:0]          pf_wr_q, pf_wr_d;
    logic [PF_AW-1:0]          pf_rd_q, pf_rd_d;
    logic [PF_AW:0]            pf_cnt_q, pf_cnt_d;

    logic [AXI_ADDR_WIDTH-1:0] fr_mem_q [FREE_DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] fr_mem_d [FREE_DEPTH];
    logic [FR_AW-1:0]          fr_wr_q, fr_wr_d;
    logic [FR_AW-1:0]          fr_rd_q, fr_rd_d;
    logic [FR_AW:0]            fr_cnt_q, fr_cnt_d;

    free_state_e               state_q, state_d;
    logic                      free_mem_q, free_mem_d;
    logic [AXI_ADDR_WIDTH-1:0] free_addr_q, free_addr_d;
    logic                      ack_q, ack_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      err_q, err_d;

    logic pf_empty, pf_full, pf_push, pf_pop;
    logic fr_empty, fr_full, fr_push, fr_pop;
    logic alloc_ack;
    logic alloc_addr_ok, rel_addr_ok;
    logic addr_err;
    logic idle_ack_err, cnt_err;

    assign pf_empty = (pf_cnt_q == '0);
    assign pf_full  = (pf_cnt_q == PF_FULL);
    assign pf_pop   = !pf_empty && buf_addr_ready_i;

    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign alloc_ack = alloc_valid_i && (!pf_full || pf_pop) && !ack_q && !rst_i;

    assign fr_empty = (fr_cnt_q == '0);
    assign fr_full  = (fr_cnt_q == FR_FULL);

`ifdef MEM_ALLOC_CLIENT_ADDR_CHECK_EN
    assign alloc_addr_ok = (alloc_addr_i[PACKET_ADDRESS_BITS-1:0] == '0);
    assign rel_addr_ok   = (rel_addr_i[PACKET_ADDRESS_BITS-1:0] == '0);
    assign addr_err      = (alloc_ack && !alloc_addr_ok) ||
                           (rel_valid_i && !fr_full && !rel_addr_ok);
`else
    assign alloc_addr_ok = 1'b1;
    assign rel_addr_ok   = 1'b1;
    assign addr_err      = 1'b0;
`endif

    assign pf_push = alloc_ack && alloc_addr_ok;
    assign fr_push = rel_valid_i && !fr_full && rel_addr_ok;

    // Prefetch FIFO bookkeeping: write on accepted offers, read when the Rx writer takes the head.
    always_comb begin
        pf_mem_d = pf_mem_q;
        pf_wr_d  = pf_wr_q;
        pf_rd_d  = pf_rd_q;
        pf_cnt_d = pf_cnt_q;
        if (pf_push) begin
            pf_mem_d[pf_wr_q] = alloc_addr_i;
            pf_wr_d           = pf_wr_q + PF_INC;
        end
        if (pf_pop) begin
            pf_rd_d = pf_rd_q + PF_INC;
        end
        if (pf_push && !pf_pop) begin
            pf_cnt_d = pf_cnt_q + PF_ONE;
        end else if (!pf_push && pf_pop) begin
            pf_cnt_d = pf_cnt_q - PF_ONE;
        end
    end

    // Release FIFO bookkeeping: write on accepted releases, read when the allocator acks a free.
    always_comb begin
        fr_mem_d = fr_mem_q;
        fr_wr_d  = fr_wr_q;
        fr_rd_d  = fr_rd_q;
        fr_cnt_d = fr_cnt_q;
        if (fr_push) begin
            fr_mem_d[fr_wr_q] = rel_addr_i;
            fr_wr_d           = fr_wr_q + FR_INC;
        end
        if (fr_pop) begin
            fr_rd_d = fr_rd_q + FR_INC;
        end
        if (fr_push && !fr_pop) begin
            fr_cnt_d = fr_cnt_q + FR_ONE;
        end else if (!fr_push && fr_pop) begin
            fr_cnt_d = fr_cnt_q - FR_ONE;
        end
    end

    // Free handshake: returning through IDLE forces a low cycle so one ack retires one entry.
    always_comb begin
        state_d      = state_q;
        free_mem_d   = free_mem_q;
        free_addr_d  = free_addr_q;
        fr_pop       = 1'b0;
        idle_ack_err = 1'b0;
        case (state_q)
            FREE_IDLE: begin
                idle_ack_err = free_mem_ack_i;
                if (!fr_empty) begin
                    state_d     = FREE_REQ;
                    free_mem_d  = 1'b1;
                    free_addr_d = fr_mem_q[fr_rd_q];
                end
            end
            FREE_REQ: begin
                if (free_mem_ack_i) begin
                    state_d    = FREE_IDLE;
                    free_mem_d = 1'b0;
                    fr_pop     = 1'b1;
                end
            end
            default: begin
                state_d    = FREE_IDLE;
                free_mem_d = 1'b0;
            end
        endcase
    end

    // Outstanding-block counter saturates at both ends and reports the attempt; errors are sticky.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_err = 1'b0;
        ack_d   = alloc_ack;
        if (alloc_ack && !fr_pop) begin
            if (cnt_q == '1) begin
                cnt_err = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (!alloc_ack && fr_pop) begin
            if (cnt_q == '0) begin
                cnt_err = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
        err_d = err_q || cnt_err || idle_ack_err || addr_err;
    end

    // State registers; reset drops any queued addresses and in-flight handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pf_mem_q    <= '{default: '0};
            pf_wr_q     <= '0;
            pf_rd_q     <= '0;
            pf_cnt_q    <= '0;
            fr_mem_q    <= '{default: '0};
            fr_wr_q     <= '0;
            fr_rd_q     <= '0;
            fr_cnt_q    <= '0;
            state_q     <= FREE_IDLE;
            free_mem_q  <= 1'b0;
            free_addr_q <= '0;
            ack_q       <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            pf_mem_q    <= pf_mem_d;
            pf_wr_q     <= pf_wr_d;
            pf_rd_q     <= pf_rd_d;
            pf_cnt_q    <= pf_cnt_d;
            fr_mem_q    <= fr_mem_d;
            fr_wr_q     <= fr_wr_d;
            fr_rd_q     <= fr_rd_d;
            fr_cnt_q    <= fr_cnt_d;
            state_q     <= state_d;
            free_mem_q  <= free_mem_d;
            free_addr_q <= free_addr_d;
            ack_q       <= ack_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign alloc_ack_o      = alloc_ack;
    assign alloc_len_o      = '1;
    assign buf_addr_o       = pf_mem_q[pf_rd_q];
    assign buf_addr_valid_o = !pf_empty;
    assign rel_ready_o      = !fr_full;
    assign free_mem_addr_o  = free_addr_q;
    assign free_mem_o       = free_mem_q;
    assign outstanding_o    = cnt_q;
    assign err_o            = err_q;

endmodule
